// File: rtl/riscv_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package riscv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned INST_W       = 32;
  localparam int unsigned PC_STEP      = 4;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [INST_W-1:0]       inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_if.sv
// Instruction-memory request/grant/response bus between the prefetcher and memory.
interface if_prefetch_if #(
  parameter int unsigned XLEN = riscv_pkg::XLEN_DEFAULT
) ();

  logic                        req;
  logic [XLEN-1:0]             addr;
  logic                        gnt;
  logic                        rvalid;
  logic [riscv_pkg::INST_W-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/if_fifo.sv
// Synchronous FIFO with occupancy count and single-cycle flush; DEPTH must be a power of 2.
module if_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i && (count_q != '0);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: nothing is read while the count is zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/if_prefetch.sv
// Decoupled instruction prefetcher: credit-limited in-order fetch into a PC-tagged FIFO,
// with redirect flush and discard of responses that belong to the old stream.
module if_prefetch
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   jmp,
  input  logic [XLEN-1:0]        new_inst_addr,
  input  logic                   if_stall,
  output logic                   inst_valid_o,
  output logic [INST_W-1:0]      inst_o,
  output logic [XLEN-1:0]        inst_addr_o,
  if_prefetch_if.master          imem,
  output logic [$clog2(DEPTH):0] outstanding_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef logic [CW-1:0] cnt_t;
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [XLEN-1:0] hold_addr_q, hold_addr_d;
  cnt_t            outstanding_q, outstanding_d;
  cnt_t            drop_cnt_q, drop_cnt_d;
  logic            stale_q, stale_d;
  logic            pending_q, pending_d;

  cnt_t            fifo_count, out_acc;
  logic            credit_ok, grant, rsp_v, rsp_drop;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [XLEN-1:0] target;
  entry_t          wr_entry, head;

  assign target    = new_inst_addr & ~XLEN'(3);
  assign credit_ok = (32'(outstanding_q) + 32'(fifo_count)) < DEPTH;

  assign imem.req  = rst_n && (pending_q || credit_ok);
  // A request caught by a redirect keeps its old address until it is granted.
  assign imem.addr = stale_q ? hold_addr_q : fetch_pc_q;

  assign grant     = imem.req && imem.gnt;
  assign rsp_v     = imem.rvalid && (outstanding_q != '0);
  assign rsp_drop  = rsp_v && (drop_cnt_q != '0);
  // Credit already guarantees space; the full term only guards against a broken memory.
  assign fifo_push = rsp_v && !rsp_drop && !jmp && !fifo_full;
  assign fifo_pop  = !fifo_empty && !if_stall && !jmp;
  assign out_acc   = outstanding_q + cnt_t'(grant) - cnt_t'(rsp_v);

  assign wr_entry.pc   = rsp_pc_q;
  assign wr_entry.inst = imem.rdata;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    hold_addr_d   = hold_addr_q;
    stale_d       = stale_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = out_acc;
    pending_d     = imem.req && !imem.gnt;

    if (rsp_drop) drop_cnt_d = drop_cnt_q - cnt_t'(1);
    if (grant) begin
      if (stale_q) begin
        drop_cnt_d = drop_cnt_d + cnt_t'(1);
        stale_d    = 1'b0;
      end else begin
        fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
      end
    end
    if (fifo_push) rsp_pc_d = rsp_pc_q + XLEN'(PC_STEP);

    if (jmp) begin
      fetch_pc_d = target;
      rsp_pc_d   = target;
      drop_cnt_d = out_acc;
      if (imem.req && !imem.gnt) begin
        stale_d     = 1'b1;
        hold_addr_d = imem.addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      hold_addr_q   <= '0;
      stale_q       <= 1'b0;
      drop_cnt_q    <= '0;
      outstanding_q <= '0;
      pending_q     <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      hold_addr_q   <= hold_addr_d;
      stale_q       <= stale_d;
      drop_cnt_q    <= drop_cnt_d;
      outstanding_q <= outstanding_d;
      pending_q     <= pending_d;
    end
  end

  if_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN + INST_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (jmp),
    .wdata_i (wr_entry),
    .rdata_o (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign inst_valid_o  = !fifo_empty;
  assign inst_o        = fifo_empty ? '0 : head.inst;
  assign inst_addr_o   = fifo_empty ? '0 : head.pc;
  assign outstanding_o = outstanding_q;

endmodule

// File: doc/if_prefetch.md
Name: if_prefetch

Overview:
Parametrised instruction-fetch unit replacing the single-register IF stage with a decoupled prefetcher. Issues in-order requests to a variable-latency instruction memory over a req/gnt/rvalid handshake and buffers returned words with their PC in a DEPTH-entry FIFO. Presents one instruction per cycle to the IF/ID register. Handles branch/jump redirects by flushing the FIFO and discarding stale in-flight responses.

Parameters:
XLEN, 32, address/PC width
DEPTH, 4, instruction FIFO entries; power of 2, >=2; also caps outstanding requests
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock
rst_n  in  1  reset
jmp  in  1  redirect strobe from branch_and_jmp
new_inst_addr  in  XLEN  redirect target
if_stall  in  1  downstream not accepting this cycle
inst_valid_o  out  1  head entry valid
inst_o  out  32  head instruction
inst_addr_o  out  XLEN  PC of head instruction
imem_req_o  out  1  fetch request
imem_addr_o  out  XLEN  fetch address, word aligned
imem_gnt_i  in  1  request accepted this cycle
imem_rvalid_i  in  1  response valid, in request order
imem_rdata_i  in  32  response data
outstanding_o  out  $clog2(DEPTH)+1  granted requests not yet returned

Behaviour:
- Reset: one clock; synchronous, active-low rst_n. All outputs 0; fetch_pc=RESET_PC, rsp_pc=RESET_PC; FIFO, outstanding, drop_cnt and stale cleared. First request can assert in the cycle after rst_n rises. Reset mid-operation drops all state; rvalid arriving with outstanding==0 is ignored.
- Issue: imem_req_o=1 when outstanding+fifo_count<DEPTH, or when a request is already pending. imem_addr_o=fetch_pc.
- Hold rule: once imem_req_o is asserted, req and addr hold until imem_gnt_i, including across jmp.
- Grant: on req&&gnt, fetch_pc+=4 and outstanding++.
- Response: on rvalid with drop_cnt>0, decrement drop_cnt and outstanding; FIFO unchanged.
- Response, not dropped: push {rsp_pc, rdata}, rsp_pc+=4, outstanding--.
- Same-cycle grant and response: net change to outstanding is 0.
- Output: inst_valid_o=!empty, head entry driven combinationally from FIFO. Pop when inst_valid_o&&!if_stall.
- Latency: response in cycle N makes inst_valid_o=1 in cycle N+1. Best-case throughput is 1 instr/cycle with single-cycle memory.
- Credit: outstanding+fifo_count<DEPTH guarantees space for every response, so push-while-full cannot occur. A push in the same cycle as a pop is legal at any occupancy.
- Redirect (jmp=1), evaluated after that cycle's grant/response accounting:
  - FIFO flushed; no pop occurs; inst_valid_o=0 next cycle.
  - fetch_pc, rsp_pc <= {new_inst_addr[XLEN-1:2],2'b00}.
  - drop_cnt <= outstanding after accounting, counting a same-cycle grant and excluding a same-cycle response.
  - A same-cycle rvalid is discarded, not pushed.
  - A pending ungranted request sets stale=1. When it is granted, drop_cnt++, stale=0, and fetch_pc is not incremented. The first new-target request issues the cycle after that grant.
- Back-to-back jmp: each applies the rules above; the latest target wins.
- Arithmetic: PC increments wrap modulo 2^XLEN. Counters are $clog2(DEPTH)+1 bits and never exceed DEPTH.

Decomposition:
- Package riscv_pkg holds XLEN default, INST_W=32, PC_STEP=4, and fifo entry struct {pc, inst}.
- One sub-module: if_fifo, a parametrised synchronous FIFO (DEPTH, WIDTH) with push, pop, flush, count, and full/empty flags.

Test Plan:
- Reset, then zero-wait memory (gnt=1, rvalid next cycle), if_stall=0 -> addr 0,4,8,… issued every cycle; inst_valid_o from cycle 3; inst_addr_o increments by 4 each cycle.
- DEPTH=4, if_stall=1 held -> exactly 4 grants, then imem_req_o=0. Release stall -> 4 pops in 4 cycles; requests resume when occupancy drops.
- 3-cycle memory latency, 2 outstanding, jmp to 0x103 -> both stale responses dropped; next inst_addr_o=0x100; drop_cnt returns to 0.
- Request pending with gnt=0 when jmp to 0x200 -> req/addr hold; after gnt, that response is dropped; next request addr=0x200.
- jmp, rvalid and pop in the same cycle -> FIFO empty next cycle, rdata discarded, no stale instruction delivered.
- rst_n=0 with 2 outstanding, later rvalid pulses -> ignored; first request after release addr=RESET_PC.
